// File: rtl/mux_32_rr_arbiter.sv
// Round-robin arbiter for a 32-input mux: drives the select, a one-hot grant and a
// valid/ready beat stream, letting each owner keep the mux for up to BURST_MAX beats.
module mux_32_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_req,
  input  logic        i_out_ready,
  output logic [4:0]  o_select,
  output logic [31:0] o_grant,
  output logic        o_out_valid
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t      r_state;
  logic [4:0]  r_pointer;
  logic [4:0]  r_beat_cnt;
  logic [4:0]  r_select;
  logic [31:0] r_grant;
  logic        r_out_valid;

  logic [4:0]  w_base;
  logic [31:0] w_rot;
  logic [4:0]  w_offset;
  logic [4:0]  w_winner;
  logic        w_any;
  logic        w_handshake;
  logic        w_stay;

  // While granted, the only arbitration that matters is the rotation one, which starts
  // just past the current owner; in IDLE it starts at the stored pointer.
  assign w_base = (r_state == ST_GRANT) ? r_select + 5'd1 : r_pointer;
  assign w_rot  = (i_req >> w_base) | (i_req << (6'd32 - {1'b0, w_base}));
  assign w_any  = |i_req;

  always_comb begin
    w_offset = '0;
    for (int k = 31; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_offset = 5'(k);
      end
    end
  end

  assign w_winner    = w_base + w_offset;
  assign w_handshake = r_out_valid & i_out_ready;
  assign w_stay      = i_req[r_select] && (({1'b0, r_beat_cnt} + 6'd1) < 6'(BURST_MAX));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pointer   <= '0;
      r_beat_cnt  <= '0;
      r_select    <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_select    <= w_winner;
            r_grant     <= 32'd1 << w_winner;
            r_out_valid <= 1'b1;
            r_beat_cnt  <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_handshake) begin
            if (w_stay) begin
              r_beat_cnt <= r_beat_cnt + 5'd1;
            end else begin
              r_pointer  <= r_select + 5'd1;
              r_beat_cnt <= '0;
              if (w_any) begin
                r_select <= w_winner;
                r_grant  <= 32'd1 << w_winner;
              end else begin
                r_grant     <= '0;
                r_out_valid <= 1'b0;
                r_state     <= ST_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_select    = r_select;
  assign o_grant     = r_grant;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_32_rr_arbiter.sv
// Bench for mux_32_rr_arbiter: two instances (BURST_MAX 4 and 1) share stimulus and are
// checked against an ownership-level reference model plus directed scenario constants.
module tb_mux_32_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] req;
  logic [4:0]  sel4, sel1;
  logic [31:0] gnt4, gnt1;
  logic        v4, v1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the mux, where the next search starts, beats taken so far.
  int m_owner[2];
  int m_ptr[2];
  int m_beats[2];
  int m_sel[2];
  int m_bm[2] = '{4, 1};

  always #5 clk = ~clk;

  mux_32_rr_arbiter #(.BURST_MAX(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_out_ready(rdy),
    .o_select(sel4), .o_grant(gnt4), .o_out_valid(v4)
  );

  mux_32_rr_arbiter #(.BURST_MAX(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_out_ready(rdy),
    .o_select(sel1), .o_grant(gnt1), .o_out_valid(v1)
  );

  function automatic int find_win(logic [31:0] r, int p);
    for (int k = 0; k < 32; k++) begin
      if (r[(p + k) % 32]) return (p + k) % 32;
    end
    return -1;
  endfunction

  function automatic logic [37:0] exp_out(int i);
    logic        v;
    logic [31:0] g;
    v = (m_owner[i] >= 0);
    g = v ? (32'd1 << m_owner[i]) : 32'd0;
    return {v, g, 5'(m_sel[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_ptr[i]   = 0;
      m_beats[i] = 0;
      m_sel[i]   = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        if (req != 0) begin
          m_owner[i] = find_win(req, m_ptr[i]);
          m_sel[i]   = m_owner[i];
          m_beats[i] = 0;
        end
      end else if (rdy) begin
        if (req[m_owner[i]] && (m_beats[i] + 1 < m_bm[i])) begin
          m_beats[i]++;
        end else begin
          m_ptr[i] = (m_owner[i] + 1) % 32;
          if (req != 0) begin
            m_owner[i] = find_win(req, m_ptr[i]);
            m_sel[i]   = m_owner[i];
          end else begin
            m_owner[i] = -1;
          end
          m_beats[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    rdy = 1'b1;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({v4, gnt4, sel4, v1, gnt1, sel1} !== 76'd0) begin
        n_err++;
        $display("FAIL reset c%0d: got v=%0b g=%h s=%0d, want all zero", c, v4, gnt4, sel4);
      end
      if (c < 2) tick();
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({v4, gnt4, sel4} !== {1'b1, 32'd1, 5'd0}) begin
      n_err++;
      $display("FAIL reset_first_grant: got v=%0b g=%h s=%0d, want v=1 g=00000001 s=0", v4, gnt4, sel4);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    req = 32'd1 << 5;
    rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++;
      if ({v4, gnt4, sel4, v1, gnt1, sel1} !== {1'b1, 32'h20, 5'd5, 1'b1, 32'h20, 5'd5}) begin
        n_err++;
        $display("FAIL burst_sole c%0d: got v=%0b g=%h s=%0d, want v=1 g=00000020 s=5", c, v4, gnt4, sel4);
      end
    end
  endtask

  task automatic test_two_ends();
    int seq[4] = '{0, 31, 0, 31};
    apply_reset();
    req = 32'h8000_0001;
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if ({v1, sel1} !== {1'b1, 5'(seq[c])} || {v4, gnt4, sel4} !== exp_out(0)) begin
        n_err++;
        $display("FAIL wrap_seq c%0d: got b1 s=%0d b4 s=%0d, want b1 s=%0d b4 s=%0d", c, sel1, sel4, seq[c], m_sel[0]);
      end
    end
    req[0] = 1'b0;
    tick();
    n_vec++;
    if ({v1, gnt1, sel1} !== {1'b1, 32'h8000_0000, 5'd31}) begin
      n_err++;
      $display("FAIL wrap_rewin: got v=%0b g=%h s=%0d, want v=1 g=80000000 s=31", v1, gnt1, sel1);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req = (32'd1 << 9) | (32'd1 << 10);
    rdy = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({v4, gnt4, sel4} !== {1'b1, 32'h200, 5'd9}) begin
        n_err++;
        $display("FAIL stall_hold c%0d: got v=%0b g=%h s=%0d, want v=1 g=00000200 s=9", c, v4, gnt4, sel4);
      end
    end
    rdy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_vec++;
      if (sel4 !== ((c < 4) ? 5'd9 : 5'd10) || v4 !== 1'b1) begin
        n_err++;
        $display("FAIL stall_release beat%0d: got v=%0b s=%0d, want v=1 s=%0d", c, v4, sel4, (c < 4) ? 9 : 10);
      end
    end
  endtask

  task automatic test_all_requesters();
    apply_reset();
    req = '1;
    rdy = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if ({v4, gnt4, sel4} !== {1'b1, 32'd1 << i, 5'(i)}) begin
        n_err++;
        $display("FAIL all_seq i%0d: got v=%0b g=%h s=%0d, want v=1 s=%0d", i, v4, gnt4, sel4, i);
      end
      req[sel4] = 1'b0;
      tick();
    end
    n_vec++;
    if ({v4, gnt4} !== {1'b0, 32'd0} || {v1, gnt1} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL all_idle: got v=%0b g=%h, want v=0 g=00000000", v4, gnt4);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 32'd1 << 17;
    rdy = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    n_vec++;
    if ({v4, sel4} !== {1'b1, 5'd17}) begin
      n_err++;
      $display("FAIL async_setup: got v=%0b s=%0d, want v=1 s=17", v4, sel4);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({v4, gnt4, sel4, v1, gnt1, sel1} !== 76'd0) begin
      n_err++;
      $display("FAIL async_clear: got v=%0b g=%h s=%0d, want all zero", v4, gnt4, sel4);
    end
    #1;
    rst = 1'b0;
    req = (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 20);
    tick();
    n_vec++;
    if ({v4, gnt4, sel4} !== {1'b1, 32'd1 << 3, 5'd3}) begin
      n_err++;
      $display("FAIL async_restart: got v=%0b g=%h s=%0d, want v=1 g=00000008 s=3", v4, gnt4, sel4);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 32'd1 << $urandom_range(0, 31);
        2:       req = $urandom & $urandom & $urandom;
        default: req = $urandom;
      endcase
      rdy = ($urandom_range(0, 9) < 7);
      tick();
      n_vec++;
      if ({v4, gnt4, sel4} !== exp_out(0)) begin
        n_err++;
        $display("FAIL rand_b4 c%0d: got v=%0b g=%h s=%0d, want %h", c, v4, gnt4, sel4, exp_out(0));
      end
      n_vec++;
      if ({v1, gnt1, sel1} !== exp_out(1)) begin
        n_err++;
        $display("FAIL rand_b1 c%0d: got v=%0b g=%h s=%0d, want %h", c, v1, gnt1, sel1, exp_out(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    test_reset();
    test_burst();
    test_two_ends();
    test_stall();
    test_all_requesters();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
